// File: rtl/pipe_mips32.sv
// pipe_mips32: five-stage MIPS32-subset core (IF/ID/EX/MEM/WB) with EX operand
// forwarding, write-through register file and a unified 1K-word memory.
module pipe_mips32 (
  input logic clk1,
  input logic rst_n
);
  localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB  = 6'd1,  OP_AND  = 6'd2,
                         OP_OR   = 6'd3,  OP_SLT  = 6'd4,  OP_MUL  = 6'd5,
                         OP_LW   = 6'd8,  OP_SW   = 6'd9,  OP_ADDI = 6'd10,
                         OP_SUBI = 6'd11, OP_SLTI = 6'd12, OP_BNEQZ = 6'd13,
                         OP_BEQZ = 6'd14, OP_HLT  = 6'd63;

  // All-zero latch contents are a bubble: no write, no store, no branch, no halt.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } ifid_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic        wen;
    logic        is_ld;
    logic        is_st;
    logic        is_br;
    logic        is_hlt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
  } idex_t;

  typedef struct packed {
    logic [4:0]  wreg;
    logic        wen;
    logic        is_ld;
    logic        is_st;
    logic        is_hlt;
    logic [31:0] alu;
    logic [31:0] b;
  } exmem_t;

  typedef struct packed {
    logic [4:0]  wreg;
    logic        wen;
    logic        is_hlt;
    logic [31:0] val;
  } memwb_t;

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:1023];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  logic        if_stop;

  ifid_t  ifid;
  idex_t  idex, id_next;
  exmem_t exmem, ex_next;
  memwb_t memwb, mem_next;

  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_rr, id_ri, wb_we, ex_taken;
  logic [31:0] fwd_a, fwd_b, alu, ex_target;

  assign id_op = ifid.ir[31:26];
  assign id_rs = ifid.ir[25:21];
  assign id_rt = ifid.ir[20:16];
  assign id_rd = ifid.ir[15:11];
  assign wb_we = memwb.wen && !HALTED;

  // Decode and register read; a same-cycle writeback is bypassed (write-through file).
  always_comb begin
    id_rr          = (id_op <= OP_MUL);
    id_ri          = (id_op == OP_ADDI) || (id_op == OP_SUBI) || (id_op == OP_SLTI);
    id_next        = '0;
    id_next.op     = id_op;
    id_next.rs     = id_rs;
    id_next.rt     = id_rt;
    id_next.wreg   = id_rr ? id_rd : id_rt;
    id_next.wen    = (id_rr || id_ri || id_op == OP_LW) && (id_next.wreg != 5'd0);
    id_next.is_ld  = (id_op == OP_LW);
    id_next.is_st  = (id_op == OP_SW);
    id_next.is_br  = (id_op == OP_BNEQZ) || (id_op == OP_BEQZ);
    id_next.is_hlt = (id_op == OP_HLT);
    id_next.a      = (wb_we && memwb.wreg == id_rs) ? memwb.val : Reg[id_rs];
    id_next.b      = (wb_we && memwb.wreg == id_rt) ? memwb.val : Reg[id_rt];
    id_next.imm    = {{16{ifid.ir[15]}}, ifid.ir[15:0]};
    id_next.npc    = ifid.npc;
  end

  // Execute: forward operands (EX/MEM ALU result first, then MEM/WB), ALU, branch resolve.
  always_comb begin
    fwd_a = idex.a;
    if (exmem.wen && !exmem.is_ld && exmem.wreg == idex.rs) fwd_a = exmem.alu;
    else if (memwb.wen && memwb.wreg == idex.rs)            fwd_a = memwb.val;
    fwd_b = idex.b;
    if (exmem.wen && !exmem.is_ld && exmem.wreg == idex.rt) fwd_b = exmem.alu;
    else if (memwb.wen && memwb.wreg == idex.rt)            fwd_b = memwb.val;
    alu = '0;
    case (idex.op)
      OP_ADD:                alu = fwd_a + fwd_b;
      OP_SUB:                alu = fwd_a - fwd_b;
      OP_AND:                alu = fwd_a & fwd_b;
      OP_OR:                 alu = fwd_a | fwd_b;
      OP_SLT:                alu = {31'd0, $signed(fwd_a) < $signed(fwd_b)};
      OP_MUL:                alu = fwd_a * fwd_b;
      OP_ADDI, OP_LW, OP_SW: alu = fwd_a + idex.imm;
      OP_SUBI:               alu = fwd_a - idex.imm;
      OP_SLTI:               alu = {31'd0, $signed(fwd_a) < $signed(idex.imm)};
      default:               alu = '0;
    endcase
    ex_taken       = idex.is_br && ((idex.op == OP_BEQZ) == (fwd_a == 32'd0));
    ex_target      = idex.npc + idex.imm;
    ex_next.wreg   = idex.wreg;
    ex_next.wen    = idex.wen;
    ex_next.is_ld  = idex.is_ld;
    ex_next.is_st  = idex.is_st;
    ex_next.is_hlt = idex.is_hlt;
    ex_next.alu    = alu;
    ex_next.b      = fwd_b;
  end

  // Memory stage: load data or ALU result heads to writeback.
  always_comb begin
    mem_next.wreg   = exmem.wreg;
    mem_next.wen    = exmem.wen;
    mem_next.is_hlt = exmem.is_hlt;
    mem_next.val    = exmem.is_ld ? Mem[exmem.alu[9:0]] : exmem.alu;
  end

  // Fetch, pipeline latches, branch redirect, HLT fetch fence and halt flag.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      if_stop      <= 1'b0;
      ifid         <= '0;
      idex         <= '0;
      exmem        <= '0;
      memwb        <= '0;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= ex_taken;
      if (ex_taken) begin
        PC   <= ex_target;
        ifid <= '0;
        idex <= '0;
      end else begin
        if (if_stop || id_next.is_hlt) begin
          ifid <= '0;
          if (id_next.is_hlt) if_stop <= 1'b1;
        end else begin
          ifid.ir  <= Mem[PC[9:0]];
          ifid.npc <= PC + 32'd1;
          PC       <= PC + 32'd1;
        end
        idex <= id_next;
      end
      exmem <= ex_next;
      memwb <= mem_next;
      if (memwb.is_hlt) HALTED <= 1'b1;
    end else begin
      TAKEN_BRANCH <= 1'b0;
    end
  end

  // Register writeback; suppressed during reset and after halt.
  always_ff @(posedge clk1) begin
    if (rst_n && wb_we) Reg[memwb.wreg] <= memwb.val;
  end

  // Store commit at the MEM edge; suppressed during reset and after halt.
  always_ff @(posedge clk1) begin
    if (rst_n && !HALTED && exmem.is_st) Mem[exmem.alu[9:0]] <= exmem.b;
  end
endmodule

// File: tb/tb_pipe_mips32.sv
// tb_pipe_mips32: directed programs; expected architectural state is queued
// per program and a monitor compares it when the core halts or a probe is raised.
module tb_pipe_mips32;
  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  pipe_mips32 dut (.clk1(clk1), .rst_n(rst_n));

  localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_HALT = 3, K_TBC = 4, K_CYC = 5, K_TBR = 6;
  typedef struct { int kind; int idx; logic [31:0] val; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, cyc = 0, tb_cnt = 0, done_cnt = 0, tgt = 0;
  bit probe = 1'b0, prev_halted = 1'b0;

  localparam logic [31:0] HLT = 32'hfc000000;

  function automatic logic [31:0] r_op(int op, int rd, int rs, int rt);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction
  function automatic logic [31:0] i_op(int op, int rt, int rs, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction
  function automatic string kname(int k);
    case (k)
      K_REG: return "reg"; K_MEM: return "mem"; K_PC: return "pc";
      K_HALT: return "halted"; K_TBC: return "taken_count";
      K_CYC: return "halt_cycle"; default: return "taken_branch";
    endcase
  endfunction

  // Cycle count since reset release and taken-branch pulse count.
  always @(posedge clk1) begin
    if (!rst_n) begin cyc = 0; tb_cnt = 0; end
    else begin cyc++; if (dut.TAKEN_BRANCH) tb_cnt++; end
  end

  task automatic drain();
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_REG:   act = dut.Reg[e.idx];
        K_MEM:   act = dut.Mem[e.idx];
        K_PC:    act = dut.PC;
        K_HALT:  act = {31'd0, dut.HALTED};
        K_TBC:   act = tb_cnt;
        K_CYC:   act = cyc;
        default: act = {31'd0, dut.TAKEN_BRANCH};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s[%0d]: got %h expected %h", kname(e.kind), e.idx, act, e.val);
      end
    end
  endtask

  // Monitor: the core presents its result when HALTED rises; probes force a snapshot.
  always @(negedge clk1) begin
    if ((dut.HALTED && !prev_halted) || probe) begin
      drain();
      probe = 1'b0;
      done_cnt++;
    end
    prev_halted = dut.HALTED;
  end

  task automatic exp_(int k, int i, logic [31:0] v);
    sb.push_back('{k, i, v});
  endtask
  task automatic put(int a, logic [31:0] w);
    dut.Mem[a] <= w;
  endtask
  task automatic setr(int r, logic [31:0] v);
    dut.Reg[r] <= v;
  endtask

  // Enter reset and preset R1..R30 to their index, R0/R31 to zero, clear low memory.
  task automatic enter_reset();
    rst_n = 1'b0;
    @(posedge clk1); #2;
    for (int i = 0; i < 32; i++) dut.Reg[i] <= (i >= 1 && i <= 30) ? i : 0;
    for (int i = 0; i < 32; i++) dut.Mem[i] <= 32'd0;
    #1;
  endtask
  task automatic release_reset();
    @(posedge clk1); #2;
    rst_n = 1'b1;
  endtask
  task automatic wait_done(int budget);
    int n = 0;
    tgt++;
    while (done_cnt < tgt && n < budget) begin @(posedge clk1); n++; end
    #2;
    checks++;
    if (done_cnt < tgt) begin
      errors++;
      $display("FAIL timeout: done events %0d expected %0d", done_cnt, tgt);
      sb.delete();
      done_cnt = tgt;
    end
  endtask

  task automatic load_t1();
    put(0, 32'h28010078); put(1, 32'h0c631800); put(2, 32'h20220000);
    put(3, 32'h0c631800); put(4, 32'h2842002d); put(5, 32'h0c631800);
    put(6, 32'h24220001); put(7, HLT);
    put(120, 32'd85); put(121, 32'd0);
  endtask
  task automatic exp_t1();
    exp_(K_MEM, 120, 85); exp_(K_MEM, 121, 130); exp_(K_REG, 1, 120);
    exp_(K_REG, 2, 130); exp_(K_CYC, 0, 12); exp_(K_PC, 0, 8); exp_(K_HALT, 0, 1);
  endtask

  initial begin
    // Load / add / store
    enter_reset(); load_t1(); exp_t1(); release_reset(); wait_done(60);

    // Back-to-back forwarding
    enter_reset();
    put(0, i_op(10, 1, 0, 10)); put(1, i_op(10, 2, 1, 20)); put(2, r_op(0, 3, 1, 2)); put(3, HLT);
    exp_(K_REG, 1, 10); exp_(K_REG, 2, 30); exp_(K_REG, 3, 40);
    exp_(K_CYC, 0, 8); exp_(K_PC, 0, 4);
    release_reset(); wait_done(60);

    // Loop with BNEQZ
    enter_reset();
    setr(1, 5); setr(2, 0);
    put(0, i_op(10, 2, 2, 3)); put(1, i_op(11, 1, 1, 1)); put(2, i_op(13, 0, 1, -3));
    put(3, HLT); put(4, i_op(10, 20, 0, 77));
    exp_(K_REG, 1, 0); exp_(K_REG, 2, 15); exp_(K_TBC, 0, 4);
    exp_(K_CYC, 0, 28); exp_(K_PC, 0, 4); exp_(K_REG, 20, 20);
    release_reset(); wait_done(80);

    // Halt fencing
    enter_reset();
    put(200, 32'hdeadbeef);
    put(0, i_op(10, 1, 0, 5)); put(1, HLT); put(2, i_op(9, 1, 0, 200)); put(3, i_op(10, 1, 0, 9));
    exp_(K_REG, 1, 5); exp_(K_CYC, 0, 6); exp_(K_PC, 0, 2);
    release_reset(); wait_done(60);
    repeat (10) @(posedge clk1); #2;
    exp_(K_PC, 0, 2); exp_(K_HALT, 0, 1); exp_(K_MEM, 200, 32'hdeadbeef);
    exp_(K_REG, 1, 5); exp_(K_TBR, 0, 0);
    probe = 1'b1; wait_done(5);

    // Misc ALU ops, R0 write discard, BEQZ skip
    enter_reset();
    setr(2, -3); setr(3, 7); setr(6, -1); setr(7, 2); setr(10, 12); setr(13, 13);
    put(0, r_op(5, 4, 2, 3));   put(1, r_op(4, 5, 6, 7));   put(2, i_op(10, 0, 0, 77));
    put(3, r_op(1, 8, 3, 2));   put(4, r_op(2, 9, 3, 10));  put(5, i_op(12, 11, 2, -5));
    put(6, r_op(4, 12, 7, 6));  put(7, i_op(14, 0, 0, 1));  put(8, i_op(10, 13, 0, 99));
    put(9, HLT);
    exp_(K_REG, 4, 32'hffffffeb); exp_(K_REG, 5, 1); exp_(K_REG, 0, 0);
    exp_(K_REG, 8, 10); exp_(K_REG, 9, 4); exp_(K_REG, 11, 0); exp_(K_REG, 12, 0);
    exp_(K_REG, 13, 13); exp_(K_TBC, 0, 1); exp_(K_CYC, 0, 15); exp_(K_PC, 0, 10);
    release_reset(); wait_done(60);

    // Reset mid-run: abort the in-flight store, then rerun from address 0
    enter_reset(); load_t1(); release_reset();
    repeat (9) @(posedge clk1); #2;
    rst_n = 1'b0;
    @(posedge clk1); #2;
    exp_(K_PC, 0, 0); exp_(K_HALT, 0, 0); exp_(K_TBR, 0, 0);
    exp_(K_MEM, 121, 0); exp_(K_MEM, 120, 85);
    probe = 1'b1;
    rst_n = 1'b1;
    wait_done(5);
    exp_t1(); wait_done(60);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d queued expectations expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/pipe_mips32.md
# pipe_mips32

Five-stage pipelined MIPS32-subset processor core (IF, ID, EX, MEM, WB) with internal register file and unified instruction/data memory. It is the top-level compute block: a bench preloads `Reg` and `Mem` hierarchically, releases reset, and the core runs until it retires `HLT`. Operand forwarding is built in. The only software rule is one independent instruction between a load and its first consumer.

## Interface

- No parameters. Memory depth is fixed at 1024 × 32-bit words and the register file at 32 × 32-bit.
- `clk1` input 1: single system clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- Internal state names are fixed because the bench accesses them hierarchically:
  - `Reg[0:31]`
  - `Mem[0:1023]`
  - `PC`
  - `HALTED`
  - `TAKEN_BRANCH`

## Operation

- **Instruction fields:** opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
  - imm is sign-extended to 32 bits.
  - PC and memory addresses are word addresses.
- **Register-register ops** (write rd = rs op rt):
  - ADD=0, SUB=1, AND=2, OR=3.
  - SLT=4: signed compare; result is 1 or 0.
  - MUL=5: low 32 bits of the product.
- **Register-immediate ops** (write rt):
  - ADDI=10, SUBI=11.
  - SLTI=12: signed compare.
- **Memory ops:**
  - LW=8: rt = Mem[rs+imm].
  - SW=9: Mem[rs+imm] = rt.
- **Branches:**
  - BNEQZ=13: taken if Reg[rs]≠0.
  - BEQZ=14: taken if Reg[rs]==0.
  - Target = (branch PC + 1) + imm.
- **HLT=63.** All other opcodes execute as NOP.
- **Arithmetic:** 32-bit two's complement, wraps mod 2^32.
- **Register 0:** writes to R0 are discarded; R0 reads as whatever is stored there (bench loads 0).
- **Register file:** write-through. A WB write in a cycle is visible to the ID read in the same cycle.
- **Forwarding into EX operands A and B** (B also supplies SW store data):
  - First priority: EX/MEM ALU result.
  - Second priority: MEM/WB result (ALU or load data).
  - Applies only when the source instruction writes a matching, non-zero register.
- **Load-use hazard:** a load followed immediately by its consumer is not interlocked. Software inserts one instruction between them.
- **Branch resolution in EX.** When taken:
  - PC ← target.
  - IF/ID and ID/EX are flushed to bubbles.
  - `TAKEN_BRANCH`=1 for that cycle, otherwise 0.
  - Instructions older than the branch complete normally.
- **HLT:**
  - When HLT is in ID, IF stops: PC frozen, bubbles fed to ID, so nothing after HLT executes.
  - HLT travels to WB and sets `HALTED`=1 there.
  - A taken branch in EX in the same cycle overrides the freeze, because the flush removes the HLT.
- **After `HALTED`=1:** no further register or memory writes; PC holds. State holds until reset.

## Timing

- **Reset** (`rst_n`=0 at a rising edge):
  - `PC`=0, `HALTED`=0, `TAKEN_BRANCH`=0.
  - All pipeline latches become bubbles: no writes, non-branch.
  - `Reg` and `Mem` are not cleared.
  - Reset mid-run aborts all in-flight instructions; no partial store or writeback occurs.
- **Pipeline timing:**
  - One instruction issued per cycle.
  - An instruction fetched at edge n writes back at edge n+4.
  - Stores commit to `Mem` at the MEM edge.
- **Branch penalty:** 2 cycles when taken, 0 when not taken.
- **Halt latency:** first fetch after reset at edge 1; HLT fetched at cycle k gives `HALTED`=1 after edge k+4.
- **Memory accesses:** single-cycle, synchronous. Out-of-range addresses use the low 10 bits.

## Test plan

- **Load / add / store:** R1..R30 preset to their index; Mem[120]=85. Program:
  - Mem[0]=28010078 (ADDI R1,R0,120)
  - Mem[1]=0c631800 (OR R3,R3,R3)
  - Mem[2]=20220000 (LW R2,0(R1))
  - Mem[3]=0c631800
  - Mem[4]=2842002d (ADDI R2,R2,45)
  - Mem[5]=0c631800
  - Mem[6]=24220001 (SW R2,1(R1))
  - Mem[7]=fc000000 (HLT)
  - Expect Mem[120]=85, Mem[121]=130, R1=120, R2=130, `HALTED`=1 within 15 cycles.
- **Back-to-back forwarding:** ADDI R1,R0,10; ADDI R2,R1,20; ADD R3,R1,R2; HLT → R3=40.
- **Loop with BNEQZ:** R1=5, R2=0; body ADDI R2,R2,3; SUBI R1,R1,1; BNEQZ R1,-3; HLT.
  - Expect R2=15 and R1=0.
  - `TAKEN_BRANCH` pulses exactly 4 times.
  - Instructions behind the taken branch are never retired.
- **Halt fencing:** SW placed after HLT does not modify memory; PC stops advancing; `HALTED` stays 1.
- **Reset:** assert `rst_n`=0 mid-program for one edge.
  - Expect `PC`=0, `HALTED`=0, no pending stores.
  - Program reruns from address 0 and produces the same results.
- **Misc:** MUL R4,R2,R3 with R2=−3, R3=7 gives −21. SLT gives 1 for −1<2. Writing R0 leaves R0 unchanged.
